// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and the parity function for the sync FIFO controller and its RAM.
package sync_fifo_pkg;

  // Widest data word the parity helper covers; callers zero-extend into it.
  localparam int unsigned ParMaxW = 256;

  function automatic int unsigned fifo_depth(input int unsigned deep);
    return 32'd1 << deep;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned deep);
    return deep + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned deep);
    return deep + 1;
  endfunction

  function automatic logic even_parity(input logic [ParMaxW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Single-clock simple dual-port RAM with a registered read port; a same-address
// write and read in one cycle returns the old word.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_in,
  input  logic             w_en,
  input  logic [AddrW-1:0] address_w,
  input  logic [Width-1:0] data_in,
  input  logic             r_en,
  input  logic [AddrW-1:0] address_r,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] mem_q [fifo_depth(AddrW)];

  always_ff @(posedge clk_in) begin
    if (w_en) begin
      mem_q[address_w] <= data_in;
    end
    if (r_en) begin
      data_o <= mem_q[address_r];
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, count, flags, sticky errors, 1-cycle read.
// Optional stored-parity checking is enabled with `define SYNC_FIFO_PARITY_EN.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned DEEP     = 3,
  parameter int unsigned AF_LEVEL = (1 << DEEP) - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic [N-1:0]              data_in,
  input  logic                      w_en,
  input  logic                      r_en,
  input  logic                      clr_err,
  output logic [N-1:0]              data_o,
  output logic                      r_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_width(DEEP)-1:0] count,
`ifdef SYNC_FIFO_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned Depth = fifo_depth(DEEP);
  localparam int unsigned PtrW  = ptr_width(DEEP);
  localparam int unsigned CntW  = cnt_width(DEEP);
`ifdef SYNC_FIFO_PARITY_EN
  localparam int unsigned RamW  = N + 1;
`else
  localparam int unsigned RamW  = N;
`endif

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfLvl    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeLvl    = CntW'(AE_LEVEL);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            r_valid_q, rd_seen_q, rd_seen_d;
  logic            overflow_q, overflow_d, underflow_q, underflow_d;
  logic            wr_acc, rd_acc;
  logic [RamW-1:0] ram_wdata, ram_rdata;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthCnt);
  assign almost_full  = (count_q >= AfLvl);
  assign almost_empty = (count_q <= AeLvl);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign r_valid      = r_valid_q;

  always_comb begin
    rd_acc      = !rst && r_en && !empty;
    wr_acc      = !rst && w_en && (!full || rd_acc);
    wr_ptr_d    = wr_ptr_q + PtrW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + PtrW'(rd_acc);
    count_d     = count_q + CntW'(wr_acc) - CntW'(rd_acc);
    rd_seen_d   = rd_seen_q | rd_acc;
    // A new error in the same cycle as clr_err wins over the clear.
    overflow_d  = (overflow_q & ~clr_err) | (w_en && full && !rd_acc);
    underflow_d = (underflow_q & ~clr_err) | (r_en && empty);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      r_valid_q   <= 1'b0;
      rd_seen_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      r_valid_q   <= rd_acc;
      rd_seen_q   <= rd_seen_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_PARITY_EN
  assign ram_wdata  = {even_parity(ParMaxW'(data_in)), data_in};
  assign parity_err = r_valid_q &&
                      (ram_rdata[N] != even_parity(ParMaxW'(ram_rdata[N-1:0])));
`else
  assign ram_wdata  = data_in;
`endif

  // The RAM read register is not reset, so mask it until the first accepted read.
  assign data_o = rd_seen_q ? ram_rdata[N-1:0] : '0;

  sync_fifo_ram #(
    .Width (RamW),
    .AddrW (DEEP)
  ) u_ram (
    .clk_in    (clk_in),
    .w_en      (wr_acc),
    .address_w (wr_ptr_q[DEEP-1:0]),
    .data_in   (ram_wdata),
    .r_en      (rd_acc),
    .address_r (rd_ptr_q[DEEP-1:0]),
    .data_o    (ram_rdata)
  );

  ptr_count_consistent: assert property (@(posedge clk_in) disable iff (rst)
    count_q == CntW'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (N=8, DEEP=3); parity checks run when
// SYNC_FIFO_PARITY_EN is defined.
module tb_sync_fifo_ctrl;

  localparam int unsigned N    = 8;
  localparam int unsigned DEEP = 3;

  logic            clk_in = 1'b0;
  logic            rst, w_en, r_en, clr_err;
  logic [N-1:0]    data_in, data_o;
  logic            r_valid, full, empty, almost_full, almost_empty;
  logic [DEEP:0]   count;
  logic            overflow, underflow;
`ifdef SYNC_FIFO_PARITY_EN
  logic            parity_err;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 clk_in = ~clk_in;

  sync_fifo_ctrl #(
    .N    (N),
    .DEEP (DEEP)
  ) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .data_in      (data_in),
    .w_en         (w_en),
    .r_en         (r_en),
    .clr_err      (clr_err),
    .data_o       (data_o),
    .r_valid      (r_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
`ifdef SYNC_FIFO_PARITY_EN
    .parity_err   (parity_err),
`endif
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] d);
    w_en    = 1'b1;
    data_in = d;
    step();
    w_en    = 1'b0;
  endtask

  task automatic pop_check(input logic [N-1:0] exp);
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("rd_data", 32'(data_o), 32'(exp));
    check("rd_valid", 32'(r_valid), 32'd1);
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) push(8'((i + 1) * 17));
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
    step();
    step();
    rst = 1'b0;

    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_valid", 32'(r_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);

    // Fill to full, then drain in order.
    for (int i = 0; i < 7; i++) begin
      push(8'((i + 1) * 17));
      check("fill_cnt", 32'(count), 32'(i + 1));
    end
    check("af_at7", 32'(almost_full), 32'd1);
    check("full_at7", 32'(full), 32'd0);
    push(8'h88);
    check("full_at8", 32'(full), 32'd1);
    check("cnt_at8", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) pop_check(8'((i + 1) * 17));
    step();
    check("valid_pulse", 32'(r_valid), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    check("data_hold", 32'(data_o), 32'h88);

    // Overflow on full: word dropped, oldest still first out.
    fill8();
    push(8'h99);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(count), 32'd8);
    pop_check(8'h11);
    check("ovf_cnt7", 32'(count), 32'd7);
    for (int i = 1; i < 8; i++) pop_check(8'((i + 1) * 17));
    check("ovf_empty", 32'(empty), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Simultaneous read and write while full.
    fill8();
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hAA;
    step();
    w_en = 1'b0; r_en = 1'b0;
    check("rw_cnt", 32'(count), 32'd8);
    check("rw_data", 32'(data_o), 32'h11);
    check("rw_valid", 32'(r_valid), 32'd1);
    check("rw_noovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) pop_check(8'((i + 1) * 17));
    pop_check(8'hAA);
    check("rw_empty", 32'(empty), 32'd1);

    // Underflow: empty read, then write+read on empty (no bypass).
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("udf_set", 32'(underflow), 32'd1);
    check("udf_novalid", 32'(r_valid), 32'd0);
    check("udf_hold", 32'(data_o), 32'hAA);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("udf_clr", 32'(underflow), 32'd0);
    w_en = 1'b1; r_en = 1'b1; data_in = 8'h5C;
    step();
    w_en = 1'b0; r_en = 1'b0;
    check("udf_wr_set", 32'(underflow), 32'd1);
    check("udf_wr_cnt", 32'(count), 32'd1);
    check("udf_wr_novalid", 32'(r_valid), 32'd0);
    check("udf_ae1", 32'(almost_empty), 32'd1);
    pop_check(8'h5C);
    r_en = 1'b1; clr_err = 1'b1;
    step();
    r_en = 1'b0; clr_err = 1'b0;
    check("set_wins", 32'(underflow), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("udf_clr2", 32'(underflow), 32'd0);

    // Reset mid-stream overrides a same-cycle write.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check("mid_cnt", 32'(count), 32'd3);
    check("mid_ae", 32'(almost_empty), 32'd0);
    rst = 1'b1; w_en = 1'b1; data_in = 8'h77;
    step();
    rst = 1'b0; w_en = 1'b0;
    check("mrst_cnt", 32'(count), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_data", 32'(data_o), 32'h00);
    check("mrst_valid", 32'(r_valid), 32'd0);
    check("mrst_wptr", 32'(dut.wr_ptr_q), 32'd0);
    check("mrst_rptr", 32'(dut.rd_ptr_q), 32'd0);
    push(8'h3C);
    pop_check(8'h3C);

`ifdef SYNC_FIFO_PARITY_EN
    check("par_ok", 32'(parity_err), 32'd0);
    push(8'h5A);
    dut.u_ram.mem_q[1][N] = ~dut.u_ram.mem_q[1][N];
    pop_check(8'h5A);
    check("par_err", 32'(parity_err), 32'd1);
    step();
    check("par_pulse", 32'(parity_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
